mpc_multipath: RTL and testbench

Parametrised multipath channel model, successor to the fixed MPC block in the baseband channel-emulation chain. It takes one signed IF sample per enabled cycle and produces the sum of NPATH delayed, individually weighted copies of the input. Path delays and gains are runtime-programmable through a simple register-write port. The output width is sized so the sum never overflows. The block sits between the IF sample source and the downstream receiver front end.

---
 rtl/mpc_multipath.sv | 136 +++++++++++++
 tb/tb_mpc_multipath.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mpc_multipath.sv
// Multipath channel model: NPATH delayed, individually weighted copies of the
// input sample summed at full precision through a three-stage pipeline.
module mpc_multipath #(
    parameter int DIN_W   = 18,
    parameter int COEF_W  = 8,
    parameter int NPATH   = 4,
    parameter int MAX_DLY = 64,
    localparam int AW     = $clog2(NPATH),
    localparam int DLY_W  = $clog2(MAX_DLY),
    localparam int DOUT_W = DIN_W + COEF_W + $clog2(NPATH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DIN_W-1:0]  Din,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [DLY_W-1:0]         cfg_dly,
    input  logic signed [COEF_W-1:0] cfg_gain,
    output logic signed [DOUT_W-1:0] OUT,
    output logic                     out_valid
);

    localparam int PROD_W = DIN_W + COEF_W;
    localparam logic signed [COEF_W-1:0] UNITY_GAIN = COEF_W'(1 << (COEF_W - 2));
    localparam logic [DLY_W-1:0] FILL_MAX = '1;

    logic signed [DIN_W-1:0]  mem [MAX_DLY];
    logic [DLY_W-1:0]         wp;
    logic [DLY_W-1:0]         fill;

    logic [DLY_W-1:0]         dly_r   [NPATH];
    logic signed [COEF_W-1:0] gain_r  [NPATH];

    logic signed [DIN_W-1:0]  tap_nxt [NPATH];
    logic signed [DIN_W-1:0]  tap_p0  [NPATH];
    logic signed [COEF_W-1:0] gain_p0 [NPATH];
    logic signed [PROD_W-1:0] prod_p1 [NPATH];
    logic signed [DOUT_W-1:0] sum_nxt;
    logic signed [DOUT_W-1:0] out_p2;
    logic                     vld_p0;
    logic                     vld_p1;
    logic                     vld_p2;

    // A zero delay bypasses the buffer; a delay reaching past the samples
    // accepted since reset yields zero so stale RAM contents never leak out.
    function automatic logic signed [DIN_W-1:0] gated_tap(
        input logic [DLY_W-1:0]        dly,
        input logic [DLY_W-1:0]        fill_cnt,
        input logic signed [DIN_W-1:0] x_now,
        input logic signed [DIN_W-1:0] x_old
    );
        if (dly == '0)
            return x_now;
        if (dly > fill_cnt)
            return '0;
        return x_old;
    endfunction

    function automatic logic signed [PROD_W-1:0] full_mul(
        input logic signed [DIN_W-1:0]  a,
        input logic signed [COEF_W-1:0] b
    );
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    always_comb begin
        for (int k = 0; k < NPATH; k++) begin
            tap_nxt[k] = gated_tap(dly_r[k], fill, Din, mem[wp - dly_r[k]]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= '0;
            fill   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            for (int k = 0; k < NPATH; k++) begin
                dly_r[k]  <= '0;
                gain_r[k] <= (k == 0) ? UNITY_GAIN : '0;
            end
        end else begin
            vld_p0 <= en;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (en) begin
                wp <= wp + DLY_W'(1);
                if (fill != FILL_MAX)
                    fill <= fill + DLY_W'(1);
            end
            if (cfg_we) begin
                dly_r[cfg_addr]  <= cfg_dly;
                gain_r[cfg_addr] <= cfg_gain;
            end
        end
    end

    // Stage p0: buffer write and tap/gain capture; the gain travels with its
    // tap so later config writes cannot disturb samples already in flight.
    always_ff @(posedge clk) begin
        if (en && !rst)
            mem[wp] <= Din;
        for (int k = 0; k < NPATH; k++) begin
            tap_p0[k]  <= tap_nxt[k];
            gain_p0[k] <= gain_r[k];
        end
    end

    // Stage p1: full-precision products.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NPATH; k++) begin
            prod_p1[k] <= full_mul(tap_p0[k], gain_p0[k]);
        end
    end

    always_comb begin
        sum_nxt = '0;
        for (int k = 0; k < NPATH; k++) begin
            sum_nxt = sum_nxt + DOUT_W'(prod_p1[k]);
        end
    end

    // Stage p2: registered sum, held between valid samples.
    always_ff @(posedge clk) begin
        if (rst)
            out_p2 <= '0;
        else if (vld_p1)
            out_p2 <= sum_nxt;
    end

    assign OUT       = out_p2;
    assign out_valid = vld_p2;

endmodule

// File: tb/tb_mpc_multipath.sv
// Scoreboard bench for mpc_multipath: directed scenarios plus random traffic
// checked against a sample-history reference model.
module tb_mpc_multipath;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [17:0] Din;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [5:0]         cfg_dly;
    logic signed [7:0]  cfg_gain;
    logic signed [27:0] OUT;
    logic               out_valid;

    mpc_multipath dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .Din       (Din),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_dly   (cfg_dly),
        .cfg_gain  (cfg_gain),
        .OUT       (OUT),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_on = 1'b0;
    longint exp_q[$];
    longint hist[$];
    int     mdly[4];
    int     mgain[4];
    longint last_out = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: every accepted sample since reset is kept; a path with delay d
    // sees the sample d positions back, or zero if that sample does not exist.
    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            mdly[k]  = 0;
            mgain[k] = (k == 0) ? 64 : 0;
        end
        last_out = 0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0)
                    check("unexpected_out_valid", 1, 0);
                else
                    check("out_value", longint'(OUT), exp_q.pop_front());
                last_out = longint'(OUT);
            end else begin
                check("out_hold", longint'(OUT), last_out);
            end
        end
    end

    task automatic cyc(input bit e, input longint d, input bit we,
                       input int a, input int dl, input int g);
        longint s;
        int n;
        @(negedge clk);
        en       = e;
        Din      = d[17:0];
        cfg_we   = we;
        cfg_addr = a[1:0];
        cfg_dly  = dl[5:0];
        cfg_gain = g[7:0];
        if (e) begin
            hist.push_back(d);
            n = hist.size() - 1;
            s = 0;
            for (int k = 0; k < 4; k++) begin
                if (n >= mdly[k])
                    s += hist[n - mdly[k]] * longint'(mgain[k]);
            end
            exp_q.push_back(s);
        end
        if (we) begin
            mdly[a]  = dl;
            mgain[a] = g;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg(input int a, input int dl, input int g);
        cyc(1'b0, 0, 1'b1, a, dl, g);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst    = 1'b1;
        en     = 1'b0;
        cfg_we = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        mon_on = 1'b1;
        @(negedge clk);
        check("reset_out", longint'(OUT), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; Din = '0;
        cfg_addr = '0; cfg_dly = '0; cfg_gain = '0;
        do_reset(2);

        // Default pass-through scaled by 64.
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        repeat (3) cyc(1'b1, 0, 1'b0, 0, 0, 0);
        idle(4);

        // Three-path impulse response, including the deepest tap.
        do_reset(1);
        cfg(0, 0, 64); cfg(1, 5, -32); cfg(2, 63, 16); cfg(3, 0, 0);
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        repeat (70) cyc(1'b1, 0, 1'b0, 0, 0, 0);
        idle(4);

        // Fill gating.
        do_reset(1);
        cfg(0, 0, 0); cfg(1, 10, 64);
        repeat (20) cyc(1'b1, 100, 1'b0, 0, 0, 0);
        idle(4);

        // Extremes; second config write overlaps samples still in flight.
        for (int k = 0; k < 4; k++) cfg(k, 0, -128);
        repeat (3) cyc(1'b1, -131072, 1'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cfg(k, 0, 127);
        repeat (3) cyc(1'b1, -131072, 1'b0, 0, 0, 0);
        idle(4);

        // Config/en collision and delays counted in samples across en gaps.
        do_reset(1);
        cfg(1, 2, 16);
        cyc(1'b1, 1000, 1'b1, 0, 0, 32);
        idle(2);
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        cyc(1'b1, 0, 1'b0, 0, 0, 0);
        idle(1);
        cyc(1'b1, 0, 1'b0, 0, 0, 0);
        cyc(1'b1, 0, 1'b0, 0, 0, 0);
        idle(4);

        // Reset with two samples in flight, then defaults restored.
        cfg(0, 0, 32);
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        do_reset(1);
        cyc(1'b1, 1000, 1'b0, 0, 0, 0);
        idle(4);

        // Random traffic with occasional resets.
        do_reset(1);
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                cyc($urandom_range(0, 3) != 0,
                    longint'($urandom_range(0, 262143)) - 131072,
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 255)) - 128);
            end
        end
        idle(6);
        check("drain_queue_empty", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
